// File: rtl/fpu_issue_arbiter.sv
// rtl/fpu_issue_arbiter.sv - two-requester round-robin issue arbiter and result router for the shared FPU
module fpu_issue_arbiter #(
  parameter int LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_opa,
  input  logic [31:0] req0_opb,
  input  logic [2:0]  req0_op,
  input  logic [1:0]  req0_rmode,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_opa,
  input  logic [31:0] req1_opb,
  input  logic [2:0]  req1_op,
  input  logic [1:0]  req1_rmode,
  output logic        fpu_start,
  output logic [31:0] fpu_opa,
  output logic [31:0] fpu_opb,
  output logic [2:0]  fpu_op,
  output logic [1:0]  fpu_rmode,
  input  logic [31:0] fpu_out,
  input  logic [4:0]  fpu_flags,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_data,
  output logic [4:0]  rsp0_flags,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_data,
  output logic [4:0]  rsp1_flags,
  output logic [4:0]  sticky0,
  output logic [4:0]  sticky1,
  input  logic        clr0,
  input  logic        clr1,
  output logic        busy
);

  logic           last;
  logic           issue_id;
  logic           grant_any;
  logic           grant_id;
  logic [LAT-1:0] tag_vld;
  logic [LAT-1:0] tag_id;
  logic           tail_rsp0;
  logic           tail_rsp1;

  // Ready is forced low during reset so every output reads 0 while it is held.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!reset && !hold) begin
      if (req0_valid && req1_valid) begin
        req0_ready = last;
        req1_ready = ~last;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  assign grant_any = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign grant_id  = req1_valid & req1_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last      <= 1'b1;
      fpu_start <= 1'b0;
      issue_id  <= 1'b0;
      fpu_opa   <= '0;
      fpu_opb   <= '0;
      fpu_op    <= '0;
      fpu_rmode <= '0;
    end else begin
      fpu_start <= grant_any;
      if (grant_any) begin
        last      <= grant_id;
        issue_id  <= grant_id;
        fpu_opa   <= grant_id ? req1_opa   : req0_opa;
        fpu_opb   <= grant_id ? req1_opb   : req0_opb;
        fpu_op    <= grant_id ? req1_op    : req0_op;
        fpu_rmode <= grant_id ? req1_rmode : req0_rmode;
      end
    end
  end

  // Tag pipe tracks the FPU datapath; its tail lines up with fpu_out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld <= {tag_vld[LAT-2:0], fpu_start};
      tag_id  <= {tag_id[LAT-2:0], issue_id};
    end
  end

  assign tail_rsp0 = tag_vld[LAT-1] & ~tag_id[LAT-1];
  assign tail_rsp1 = tag_vld[LAT-1] &  tag_id[LAT-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp0_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp0_flags <= '0;
      rsp1_valid <= 1'b0;
      rsp1_data  <= '0;
      rsp1_flags <= '0;
      sticky0    <= '0;
      sticky1    <= '0;
    end else begin
      rsp0_valid <= tail_rsp0;
      rsp1_valid <= tail_rsp1;
      if (tail_rsp0) begin
        rsp0_data  <= fpu_out;
        rsp0_flags <= fpu_flags;
      end
      if (tail_rsp1) begin
        rsp1_data  <= fpu_out;
        rsp1_flags <= fpu_flags;
      end
      // A clear coinciding with a response keeps that response's flags.
      sticky0 <= (clr0 ? 5'd0 : sticky0) | (rsp0_valid ? rsp0_flags : 5'd0);
      sticky1 <= (clr1 ? 5'd0 : sticky1) | (rsp1_valid ? rsp1_flags : 5'd0);
    end
  end

  assign busy = fpu_start | (|tag_vld) | rsp0_valid | rsp1_valid;

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// tb/tb_fpu_issue_arbiter.sv - directed scoreboard bench for fpu_issue_arbiter
module tb_fpu_issue_arbiter;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic reset, hold, clr0, clr1;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_opa, req0_opb, req1_opa, req1_opb;
  logic [2:0] req0_op, req1_op;
  logic [1:0] req0_rmode, req1_rmode;
  logic fpu_start;
  logic [31:0] fpu_opa, fpu_opb, fpu_out;
  logic [2:0] fpu_op;
  logic [1:0] fpu_rmode;
  logic [4:0] fpu_flags;
  logic rsp0_valid, rsp1_valid, busy;
  logic [31:0] rsp0_data, rsp1_data;
  logic [4:0] rsp0_flags, rsp1_flags, sticky0, sticky1;

  fpu_issue_arbiter #(.LAT(LAT)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opa(req0_opa), .req0_opb(req0_opb),
    .req0_op(req0_op), .req0_rmode(req0_rmode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opa(req1_opa), .req1_opb(req1_opb),
    .req1_op(req1_op), .req1_rmode(req1_rmode),
    .fpu_start(fpu_start), .fpu_opa(fpu_opa), .fpu_opb(fpu_opb), .fpu_op(fpu_op), .fpu_rmode(fpu_rmode),
    .fpu_out(fpu_out), .fpu_flags(fpu_flags),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_flags(rsp1_flags),
    .sticky0(sticky0), .sticky1(sticky1), .clr0(clr0), .clr1(clr1), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic [4:0]  flags;
  } rsp_t;

  rsp_t sb[$];
  rsp_t exp_rsp;
  int checks = 0;
  int errors = 0;
  logic mlast;
  logic [31:0] a0, b0, a1, b1;
  logic [2:0] op0, op1;
  logic [1:0] rm0, rm1;

  // FPU stand-in: 1.0+2.0 gives 3.0, anything else gives a^b; flags come from opb[4:0].
  function automatic logic [36:0] fpu_fn(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return {32'h4040_0000, 5'd0};
    return {a ^ b, b[4:0]};
  endfunction

  logic [31:0] pa [LAT];
  logic [31:0] pb [LAT];
  always @(posedge clk) begin
    pa[0] <= fpu_opa;
    pb[0] <= fpu_opb;
    for (int i = 1; i < LAT; i++) begin
      pa[i] <= pa[i-1];
      pb[i] <= pb[i-1];
    end
  end
  assign {fpu_out, fpu_flags} = fpu_fn(pa[LAT-1], pb[LAT-1]);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && (rsp0_valid || rsp1_valid)) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", {rsp1_valid, rsp0_valid}, 64'd0);
      end else begin
        exp_rsp = sb.pop_front();
        check("rsp_one_hot", rsp0_valid & rsp1_valid, 64'd0);
        check("rsp_id", rsp1_valid, exp_rsp.id);
        check("rsp_data", exp_rsp.id ? rsp1_data : rsp0_data, exp_rsp.data);
        check("rsp_flags", exp_rsp.id ? rsp1_flags : rsp0_flags, exp_rsp.flags);
      end
    end
  end

  task automatic randomize_ops();
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    op0 = 3'($urandom); op1 = 3'($urandom); rm0 = 2'($urandom); rm1 = 2'($urandom);
  endtask

  task automatic cycle(input logic v0, input logic v1, input logic h, input logic c0, input logic c1);
    logic e0, e1;
    logic [36:0] res;
    @(negedge clk);
    req0_valid = v0; req1_valid = v1; hold = h; clr0 = c0; clr1 = c1;
    req0_opa = a0; req0_opb = b0; req0_op = op0; req0_rmode = rm0;
    req1_opa = a1; req1_opb = b1; req1_op = op1; req1_rmode = rm1;
    #1;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!h) begin
      if (v0 && v1) begin
        e0 = mlast;
        e1 = ~mlast;
      end else begin
        e0 = v0;
        e1 = v1;
      end
    end
    check("req0_ready", req0_ready, e0);
    check("req1_ready", req1_ready, e1);
    if (e0 || e1) begin
      res = fpu_fn(e1 ? a1 : a0, e1 ? b1 : b0);
      sb.push_back('{id: e1, data: res[36:5], flags: res[4:0]});
      mlast = e1;
    end
    @(posedge clk);
    randomize_ops();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    randomize_ops();
    req0_opa = a0; req0_opb = b0; req0_op = op0; req0_rmode = rm0;
    req1_opa = a1; req1_opb = b1; req1_op = op1; req1_rmode = rm1;
    mlast = 1'b1;
    #13;
    check("rst_ready0", req0_ready, 0);
    check("rst_start", fpu_start, 0);
    check("rst_busy", busy, 0);
    check("rst_sticky0", sticky0, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    req0_valid = 1'b0;

    // single op, exact latency
    a0 = 32'h3F80_0000; b0 = 32'h4000_0000; op0 = 3'd0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    check("single_start", fpu_start, 1);
    check("single_opa", fpu_opa, 32'h3F80_0000);
    check("single_opb", fpu_opb, 32'h4000_0000);
    check("single_op", fpu_op, 3'd0);
    for (int k = 1; k <= LAT + 1; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #2;
      if (k == 1) check("single_start_once", fpu_start, 0);
      check("single_rsp0_valid", rsp0_valid, (k == LAT + 1) ? 1 : 0);
      check("single_rsp1_valid", rsp1_valid, 0);
      if (k == LAT + 1) check("single_rsp0_data", rsp0_data, 32'h4040_0000);
    end
    idle(1);
    #2;
    check("single_busy_done", busy, 0);

    // tie alternation, preceded by a req1 grant so req0 wins the first tie
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(LAT + 3);
    check("tie_drained", sb.size(), 0);

    // req1 streaming
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      #2;
      check("stream_start", fpu_start, 1);
    end
    idle(LAT + 1);
    #2;
    check("stream_busy_last", busy, 1);
    check("stream_last_rsp1", rsp1_valid, 1);
    idle(1);
    #2;
    check("stream_busy_fall", busy, 0);

    // sticky flags with a coincident clear
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    #2;
    check("sticky0_cleared", sticky0, 0);
    check("sticky1_cleared", sticky1, 0);
    b0 = 32'h0000_0010;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(LAT + 2);
    #2;
    check("sticky0_first", sticky0, 5'b10000);
    b0 = 32'h0000_0001;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(LAT + 1);
    #2;
    check("sticky0_before_clr", sticky0, 5'b10000);
    check("sticky0_rsp_cycle", rsp0_valid, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    check("sticky0_clr_set", sticky0, 5'b00001);
    idle(1);

    // hold blocks grants while in-flight ops drain
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < LAT + 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("hold_drained", sb.size(), 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    check("hold_release_start", fpu_start, 1);
    idle(LAT + 3);

    // reset mid-flight
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    #2;
    check("pre_reset_busy", busy, 1);
    reset = 1'b1;
    req0_valid = 1'b1;
    #1;
    check("mid_rst_ready0", req0_ready, 0);
    check("mid_rst_start", fpu_start, 0);
    check("mid_rst_opa", fpu_opa, 0);
    check("mid_rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    check("mid_rst_rsp0_data", rsp0_data, 0);
    check("mid_rst_sticky", {sticky1, sticky0}, 0);
    check("mid_rst_busy", busy, 0);
    sb.delete();
    mlast = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    req0_valid = 1'b0;
    idle(LAT + 3);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    check("post_rst_tie_opa", fpu_opa, sb.size() == 1 && sb[0].id == 1'b0 ? req0_opa : 32'hDEAD_BEEF);
    idle(LAT + 3);
    check("final_drained", sb.size(), 0);
    check("final_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
